dpi_stream_sequencer: RTL and testbench
=======================================

// Module: dpi_stream_sequencer
// PURPOSE
//  Front-end controller for the bank of per-regex match wrappers (state save/restore, count, fired).
//  Accepts a byte stream tagged with a 6-bit stream id and generates the load_state / char / eop sequence.
//  Tracks which stream ids have been seen; applies a per-stream regex-enable mask; collects fired flags
//  into one result record per packet. Sits between the packet parser and the regex bank.
// PARAMETERS
//  NUM_REGEX    8    number of regex wrappers driven (width of enable / fired vectors)
//  DRAIN_CYCLES 2    idle cycles after last char before eop (covers regex accept + flag latency), >=1
//  EN_RST_VAL   1    reset value of every bit of every per-stream enable mask (0 or 1)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          synchronous reset, active-low
//  in_valid       in   1          input byte valid
//  in_ready       out  1          input byte accepted when in_valid & in_ready
//  in_data        in   8          payload byte
//  in_sop         in   1          first byte of packet; carries in_stream_id
//  in_eop         in   1          last byte of packet (may equal sop beat)
//  in_stream_id   in   6          stream id, sampled on sop beat only
//  cfg_we         in   1          write enable mask for stream cfg_addr
//  cfg_addr       in   6          stream id for cfg write
//  cfg_data       in   NUM_REGEX  enable mask value
//  cfg_clr_seen   in   1          pulse: clear all seen bits
//  load_state     out  1          to regex bank: restore state for stream_id
//  new_stream_id  out  1          to regex bank: stream not seen before (valid with load_state)
//  stream_id      out  6          to regex bank: held from LOAD through EOP
//  enable         out  NUM_REGEX  to regex bank: latched mask, held from LOAD through EOP
//  char_in        out  8          to regex bank: byte
//  char_in_vld    out  1          to regex bank: byte valid
//  eop            out  1          to regex bank: one-cycle packet end
//  fired          in   NUM_REGEX  from regex bank: per-regex speculative match flag
//  res_valid      out  1          result record valid (holds until res_ready)
//  res_ready      in   1          result consumer ready
//  res_stream_id  out  6          result stream id
//  res_fired      out  NUM_REGEX  fired & enable, sampled in EOP cycle
//  pkt_count      out  16         packets completed, saturating
//  drop_count     out  16         non-sop beats dropped in IDLE, saturating
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 except in_ready=1; seen[63:0]=0; enable masks={NUM_REGEX{EN_RST_VAL}}.
//  Reset mid-packet: abandon packet, no eop, no result; regex-bank state left as-is.
//  FSM: IDLE -> LOAD -> WAIT -> STREAM -> DRAIN -> EOP -> IDLE.
//   IDLE:   in_ready=1. Beat with in_sop: latch stream_id, byte, in_eop, mask[id], seen[id]; go LOAD.
//           Beat without in_sop: drop, drop_count++.
//   LOAD:   1 cycle; load_state=1; new_stream_id=~seen[stream_id]; in_ready=0.
//   WAIT:   1 cycle (bank applies state_in); in_ready=0.
//   STREAM: first cycle replays latched sop byte (char_in_vld=1, in_ready=0). Later cycles in_ready=1;
//           accepted beat -> char_in=in_data, char_in_vld=1 same cycle (combinational pass-through).
//           Leave for DRAIN after the byte flagged in_eop is presented. in_sop inside packet: treated as data.
//   DRAIN:  DRAIN_CYCLES cycles, char_in_vld=0, in_ready=0.
//   EOP:    wait while res_valid & ~res_ready (stall, eop low). Then eop=1 one cycle;
//           res_fired<=fired&enable, res_stream_id<=stream_id, res_valid<=1; seen[stream_id]<=1; pkt_count++.
//  Latency: sop accept -> first char_in_vld = 3 cycles; last char -> eop = DRAIN_CYCLES+1 cycles min.
//  res_valid clears on res_valid & res_ready; may be set again same cycle by EOP (new record wins).
//  Config: cfg_we writes mask any time; current packet unaffected (mask latched in IDLE).
//  cfg_clr_seen same cycle as EOP seen-set: clear wins (stream stays unseen).
//  Counters saturate at 16'hFFFF.
// STRUCTURE
//  Shared package dpi_pkg: STREAM_ID_W=6, NUM_STREAMS=64, state encoding localparams.
//  Sub-module dpi_stream_cfg_table: 64 x NUM_REGEX mask RAM + seen vector, 1 write, 1 async read.
// TESTING
//  1. 3-byte pkt id 5, seen clear -> load_state+new_stream_id=1 cycle 1; chars 3..5; eop at 8 (DRAIN=2).
//  2. Second pkt id 5 -> new_stream_id=0; cfg_clr_seen then pkt id 5 -> new_stream_id=1.
//  3. mask[9]=8'h0F, fired=8'hFF at eop -> res_fired=8'h0F, res_stream_id=9.
//  4. 1-byte pkt (sop&eop) -> single char_in_vld; res_ready=0 across two pkts -> 2nd eop stalls.
//  5. Non-sop beat in IDLE -> dropped, drop_count=1, no load_state.
//  6. rst_n low in STREAM -> next cycle IDLE, no eop/result; seen and masks back to reset values.

Source files
------------

// File: rtl/dpi_pkg.sv
// dpi_pkg: shared widths and FSM encoding for the DPI stream front-end.
package dpi_pkg;
  localparam int STREAM_ID_W = 6;
  localparam int NUM_STREAMS = 64;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_EOP    = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_WAIT   = ST_WAIT,
    S_STREAM = ST_STREAM,
    S_DRAIN  = ST_DRAIN,
    S_EOP    = ST_EOP
  } state_e;
endpackage

// File: rtl/dpi_stream_cfg_table.sv
// dpi_stream_cfg_table: per-stream regex-enable masks plus seen bits, one write port, async read.
module dpi_stream_cfg_table
  import dpi_pkg::*;
#(
  parameter int NUM_REGEX  = 8,
  parameter int EN_RST_VAL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mask_we_i,
  input  logic [STREAM_ID_W-1:0] mask_waddr_i,
  input  logic [NUM_REGEX-1:0]   mask_wdata_i,
  input  logic                   seen_set_i,
  input  logic [STREAM_ID_W-1:0] seen_addr_i,
  input  logic                   seen_clr_i,
  input  logic [STREAM_ID_W-1:0] rd_addr_i,
  output logic [NUM_REGEX-1:0]   rd_mask_o,
  output logic                   rd_seen_o
);
  localparam logic [NUM_REGEX-1:0] MASK_RST = (EN_RST_VAL != 0) ? {NUM_REGEX{1'b1}} : '0;
  logic [NUM_REGEX-1:0]   mask_q [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] seen_q;
  // a bulk clear beats a same-cycle set so the stream stays unseen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STREAMS; i++) mask_q[i] <= MASK_RST;
      seen_q <= '0;
    end else begin
      if (mask_we_i) mask_q[mask_waddr_i] <= mask_wdata_i;
      if (seen_clr_i) seen_q <= '0;
      else if (seen_set_i) seen_q[seen_addr_i] <= 1'b1;
    end
  end
  assign rd_mask_o = mask_q[rd_addr_i];
  assign rd_seen_o = seen_q[rd_addr_i];
endmodule

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: turns a tagged byte stream into load_state/char/eop sequences for the
// regex bank and gathers the bank's fired flags into one result record per packet.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int NUM_REGEX    = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int EN_RST_VAL   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [STREAM_ID_W-1:0] in_stream_id,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [NUM_REGEX-1:0]   cfg_data,
  input  logic                   cfg_clr_seen,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic [NUM_REGEX-1:0]   enable,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  input  logic [NUM_REGEX-1:0]   fired,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [STREAM_ID_W-1:0] res_stream_id,
  output logic [NUM_REGEX-1:0]   res_fired,
  output logic [15:0]            pkt_count,
  output logic [15:0]            drop_count
);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  state_e                 state_q, state_d;
  logic [STREAM_ID_W-1:0] sid_q, sid_d;
  logic [NUM_REGEX-1:0]   en_q, en_d;
  logic [7:0]             byte_q, byte_d;
  logic                   last_q, last_d;
  logic                   seen_q, seen_d;
  logic                   first_q, first_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   res_valid_q, res_valid_d;
  logic [STREAM_ID_W-1:0] res_sid_q;
  logic [NUM_REGEX-1:0]   res_fired_q;
  logic [15:0]            pkt_q, drop_q;
  logic                   fire, drop;
  logic [NUM_REGEX-1:0]   rd_mask;
  logic                   rd_seen;
  dpi_stream_cfg_table #(.NUM_REGEX(NUM_REGEX), .EN_RST_VAL(EN_RST_VAL)) u_cfg (
    .clk          (clk),
    .rst_n        (rst_n),
    .mask_we_i    (cfg_we),
    .mask_waddr_i (cfg_addr),
    .mask_wdata_i (cfg_data),
    .seen_set_i   (fire),
    .seen_addr_i  (sid_q),
    .seen_clr_i   (cfg_clr_seen),
    .rd_addr_i    (in_stream_id),
    .rd_mask_o    (rd_mask),
    .rd_seen_o    (rd_seen)
  );
  always_comb begin
    state_d       = state_q;
    sid_d         = sid_q;
    en_d          = en_q;
    byte_d        = byte_q;
    last_d        = last_q;
    seen_d        = seen_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    load_state    = 1'b0;
    new_stream_id = 1'b0;
    char_in       = '0;
    char_in_vld   = 1'b0;
    eop           = 1'b0;
    fire          = 1'b0;
    drop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        drop     = in_valid & ~in_sop;
        if (in_valid && in_sop) begin
          state_d = S_LOAD;
          sid_d   = in_stream_id;
          en_d    = rd_mask;
          byte_d  = in_data;
          last_d  = in_eop;
          seen_d  = rd_seen;
        end
      end
      S_LOAD: begin
        load_state    = 1'b1;
        new_stream_id = ~seen_q;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        first_d = 1'b1;
        state_d = S_STREAM;
      end
      // first STREAM cycle replays the byte captured with sop; later bytes pass straight through
      S_STREAM: begin
        in_ready    = ~first_q;
        char_in_vld = first_q | in_valid;
        char_in     = first_q ? byte_q : in_data;
        first_d     = 1'b0;
        cnt_d       = '0;
        if (first_q ? last_q : (in_valid & in_eop)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == DRAIN_LAST) ? S_EOP : S_DRAIN;
      end
      S_EOP: begin
        fire    = ~(res_valid_q & ~res_ready);
        eop     = fire;
        state_d = fire ? S_IDLE : S_EOP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign res_valid_d = fire | (res_valid_q & ~res_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sid_q       <= '0;
      en_q        <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      seen_q      <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_sid_q   <= '0;
      res_fired_q <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sid_q       <= sid_d;
      en_q        <= en_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      seen_q      <= seen_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      if (fire) begin
        res_sid_q   <= sid_q;
        res_fired_q <= fired & en_q;
      end
      pkt_q  <= pkt_q + 16'(fire && pkt_q != 16'hFFFF);
      drop_q <= drop_q + 16'(drop && drop_q != 16'hFFFF);
    end
  end
  assign stream_id     = sid_q;
  assign enable        = en_q;
  assign res_valid     = res_valid_q;
  assign res_stream_id = res_sid_q;
  assign res_fired     = res_fired_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed literal checks plus randomized traffic against a timing-rule model.
module tb_dpi_stream_sequencer;
  localparam int NR = 8;
  localparam int DR = 2;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_sop = 0, in_eop = 0;
  logic [7:0] in_data = 0;
  logic [5:0] in_stream_id = 0;
  logic cfg_we = 0, cfg_clr_seen = 0;
  logic [5:0] cfg_addr = 0;
  logic [NR-1:0] cfg_data = 0;
  logic load_state, new_stream_id, char_in_vld, eop, res_valid, res_ready = 1;
  logic [5:0] stream_id, res_stream_id;
  logic [NR-1:0] enable, res_fired, fired = 0;
  logic [7:0] char_in;
  logic [15:0] pkt_count, drop_count;

  dpi_stream_sequencer #(.NUM_REGEX(NR), .DRAIN_CYCLES(DR), .EN_RST_VAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_clr_seen(cfg_clr_seen),
    .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
    .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop), .fired(fired),
    .res_valid(res_valid), .res_ready(res_ready), .res_stream_id(res_stream_id),
    .res_fired(res_fired), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0, pass = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // model: packet progress measured in cycles since sop acceptance and since the last char
  logic [NR-1:0] mask_m [64];
  bit [63:0] seen_m;
  bit in_pkt, got_last, rv_m, new_m, last0_m, was_pkt;
  int ss, sl, pc_m, dc_m;
  logic [5:0] id_m, rid_m;
  logic [NR-1:0] en_m, rf_m;
  logic [7:0] b0_m, ch_e;
  bit ld_e, vld_e, rdy_e, eop_e, lastc;
  int nload = 0, nchar = 0, neop = 0;
  logic last_new;
  logic [13:0] last_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mask_m[i] = '1;
      seen_m = '0; in_pkt = 0; got_last = 0; rv_m = 0; ss = 0; sl = 0; pc_m = 0; dc_m = 0;
      id_m = '0; en_m = '0; rid_m = '0; rf_m = '0;
    end else begin
      ld_e  = in_pkt && ss == 1;
      vld_e = in_pkt && (ss == 3 || (ss > 3 && !got_last && in_valid));
      ch_e  = (ss == 3) ? b0_m : in_data;
      rdy_e = !in_pkt || (ss > 3 && !got_last);
      eop_e = in_pkt && got_last && sl >= DR + 1 && !(rv_m && !res_ready);
      chk("in_ready", 32'(in_ready), 32'(rdy_e));
      chk("load_state", 32'(load_state), 32'(ld_e));
      chk("new_stream_id", 32'(new_stream_id), 32'(ld_e && new_m));
      chk("char_in_vld", 32'(char_in_vld), 32'(vld_e));
      if (vld_e) chk("char_in", 32'(char_in), 32'(ch_e));
      chk("eop", 32'(eop), 32'(eop_e));
      if (in_pkt) begin
        chk("stream_id", 32'(stream_id), 32'(id_m));
        chk("enable", 32'(enable), 32'(en_m));
      end
      chk("res_valid", 32'(res_valid), 32'(rv_m));
      if (rv_m) chk("res_record", {18'd0, res_stream_id, res_fired}, {18'd0, rid_m, rf_m});
      chk("pkt_count", 32'(pkt_count), 32'(pc_m));
      chk("drop_count", 32'(drop_count), 32'(dc_m));
      nload += 32'(load_state); nchar += 32'(char_in_vld); neop += 32'(eop);
      if (load_state) last_new = new_stream_id;
      if (res_valid && res_ready) last_res = {res_stream_id, res_fired};
      was_pkt = in_pkt;
      lastc = vld_e && ((ss == 3) ? last0_m : in_eop);
      if (rv_m && res_ready) rv_m = 0;
      if (eop_e) begin
        rv_m = 1; rid_m = id_m; rf_m = fired & en_m; seen_m[id_m] = 1;
        if (pc_m < 65535) pc_m++;
        in_pkt = 0; got_last = 0;
      end
      if (!was_pkt && in_valid) begin
        if (in_sop) begin
          in_pkt = 1; ss = 1; got_last = 0; id_m = in_stream_id; en_m = mask_m[in_stream_id];
          b0_m = in_data; last0_m = in_eop; new_m = !seen_m[in_stream_id];
        end else if (dc_m < 65535) dc_m++;
      end else if (was_pkt && in_pkt && ss < 1000) ss++;
      if (lastc) begin got_last = 1; sl = 1; end
      else if (got_last) sl++;
      if (cfg_clr_seen) seen_m = '0;
      if (cfg_we) mask_m[cfg_addr] = cfg_data;
    end
  end

  bit rnd_on = 0;
  always @(posedge clk) if (rnd_on) begin
    #1;
    res_ready = $urandom_range(0, 3) != 0;
    fired = NR'($urandom);
    cfg_we = $urandom_range(0, 15) == 0;
    cfg_addr = 6'($urandom_range(0, 15));
    cfg_data = NR'($urandom);
    cfg_clr_seen = $urandom_range(0, 31) == 0;
  end

  initial begin #500000; $display("FAIL watchdog: run did not finish"); $fatal(1); end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input bit s, input bit e, input logic [5:0] id, input logic [7:0] d);
    int k = 0;
    in_valid = 1; in_sop = s; in_eop = e; in_stream_id = id; in_data = d;
    do begin @(negedge clk); k++; end while (!in_ready && k < 200);
    if (!in_ready) chk("beat_accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic pkt(input logic [5:0] id, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      beat(i == 0 || $urandom_range(0, 7) == 0, i == len - 1, id, 8'($urandom));
      idle($urandom_range(0, gap));
    end
  endtask

  task automatic pulse_cfg(input logic [5:0] a, input logic [NR-1:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d; idle(1); cfg_we = 0;
  endtask

  int n0, ndrop = 0;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_outputs", 32'({in_ready, load_state, char_in_vld, eop, res_valid, enable}), 32'(13'h1000));
    @(posedge clk); #1;
    // 3-byte packet on stream 5: load at 1, chars at 3..5, eop at 3+2+DR+1 = 8
    fired = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 0 || i == 4 || i == 5); in_sop = (i == 0); in_eop = (i == 5);
      in_stream_id = 6'd5; in_data = (i == 0) ? 8'hA1 : (i == 4) ? 8'hA2 : 8'hA3;
      @(negedge clk);
      if (i == 1) chk("d1_load", 32'({load_state, new_stream_id, stream_id}), 32'({2'b11, 6'd5}));
      if (i == 2) chk("d1_wait", 32'({load_state, char_in_vld}), 32'(0));
      if (i >= 3 && i <= 5) chk("d1_char", 32'({char_in_vld, char_in}), 32'({1'b1, 8'(8'hA0 + i - 2)}));
      if (i == 6 || i == 7) chk("d1_drain", 32'({char_in_vld, eop}), 32'(0));
      if (i == 8) chk("d1_eop", 32'({eop, enable}), 32'(9'h1FF));
      if (i == 9) chk("d1_result", 32'({res_valid, res_stream_id, res_fired, pkt_count}), {1'b1, 6'd5, 8'h3C, 16'd1, 1'b0} >> 1);
      @(posedge clk); #1;
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
    // seen tracking and clear
    pkt(6'd5, 2, 0); idle(12);
    chk("d2_seen", 32'(last_new), 32'(0));
    cfg_clr_seen = 1; idle(1); cfg_clr_seen = 0;
    pkt(6'd5, 1, 0); idle(12);
    chk("d2_cleared", 32'(last_new), 32'(1));
    // masked fired flags
    pulse_cfg(6'd9, 8'h0F); fired = 8'hFF;
    pkt(6'd9, 3, 0); idle(12);
    chk("d3_result", 32'(last_res), 32'({6'd9, 8'h0F}));
    // single-byte packet and result back-pressure
    n0 = nchar;
    pkt(6'd12, 1, 0); idle(12);
    chk("d4_one_char", 32'(nchar - n0), 32'(1));
    res_ready = 0; n0 = neop;
    pkt(6'd13, 2, 0); pkt(6'd14, 1, 0); idle(20);
    chk("d4_stall_eops", 32'(neop - n0), 32'(1));
    chk("d4_held", 32'({res_valid, res_stream_id}), 32'({1'b1, 6'd13}));
    res_ready = 1; idle(12);
    chk("d4_released", 32'(neop - n0), 32'(2));
    chk("d4_second", 32'(last_res[13:8]), 32'(14));
    // stray beat in idle
    n0 = nload;
    beat(0, 0, 6'd3, 8'h55); idle(3);
    chk("d5_drop", 32'(drop_count), 32'(1));
    chk("d5_no_load", 32'(nload - n0), 32'(0));
    // reset in the middle of a packet
    beat(1, 0, 6'd7, 8'h11); beat(0, 0, 6'd7, 8'h22);
    rst_n = 0; idle(1); rst_n = 1;
    n0 = neop; idle(10);
    chk("d6_no_eop", 32'(neop - n0), 32'(0));
    chk("d6_counters", 32'({res_valid, pkt_count, drop_count}), 32'(0));
    pkt(6'd9, 1, 0); idle(12);
    chk("d6_mask_reset", 32'(last_res), 32'({6'd9, 8'hFF}));
    chk("d6_seen_reset", 32'(last_new), 32'(1));
    // randomized traffic
    rnd_on = 1;
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 9) == 0) begin beat(0, 0, 6'd0, 8'($urandom)); ndrop++; end
      pkt(6'($urandom_range(0, 15)), $urandom_range(1, 6), 3);
    end
    rnd_on = 0;
    @(posedge clk); #2;
    res_ready = 1; cfg_we = 0; cfg_clr_seen = 0;
    idle(30);
    chk("final_pkts", 32'(pkt_count), 32'(151));
    chk("final_drops", 32'(drop_count), 32'(ndrop));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
